// File: rtl/dmem_ctrl.sv
// Load/store sequencer for the word-wide data_mem: sub-word stores use read-modify-write, loads are lane-extracted and extended.
// Optional misaligned-access trap is compiled in with `define DMEM_MISALIGN_TRAP_EN.
module dmem_ctrl #(
    parameter int REG_SIZE = 32,
    parameter int ADDR_W   = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [1:0]          size_i,
    input  logic                unsigned_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [REG_SIZE-1:0] wdata_i,
    output logic                ready_o,
    output logic                done_o,
    output logic [REG_SIZE-1:0] rdata_o,
    output logic                err_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [REG_SIZE-1:0] mem_wdata_o,
    input  logic [REG_SIZE-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, RD, WR, ERR} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   memAddr_q, memAddr_d;
    logic [1:0]          off_q, off_d;
    logic [1:0]          size_q, size_d;
    logic                we_q, we_d;
    logic                uns_q, uns_d;
    logic [REG_SIZE-1:0] wdata_q, wdata_d;
    logic [REG_SIZE-1:0] merge_q, merge_d;

    logic [7:0]          byteVal;
    logic [15:0]         halfVal;
    logic [REG_SIZE-1:0] loadExt;
    logic [REG_SIZE-1:0] mergedWord;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((size_i == 2'b01) && addr_i[0]) || (size_i[1] && (addr_i[1:0] != 2'b00));
    assign err_o      = (state_q == ERR);
`else
    assign err_o      = 1'b0;
`endif

    assign ready_o     = (state_q == IDLE);
    assign mem_addr_o  = ((state_q == RD) || (state_q == WR)) ? addr_q : memAddr_q;
    assign mem_wdata_o = mergedWord;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            memAddr_q <= '0;
            off_q     <= 2'b00;
            size_q    <= 2'b00;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            wdata_q   <= '0;
            merge_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            memAddr_q <= memAddr_d;
            off_q     <= off_d;
            size_q    <= size_d;
            we_q      <= we_d;
            uns_q     <= uns_d;
            wdata_q   <= wdata_d;
            merge_q   <= merge_d;
        end
    end

    // Half accesses select by off[1] only, so an untrapped odd half address rounds down.
    always_comb begin
        byteVal = mem_rdata_i[{off_q, 3'b000} +: 8];
        halfVal = mem_rdata_i[{off_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   loadExt = {{(REG_SIZE-8){~uns_q & byteVal[7]}}, byteVal};
            2'b01:   loadExt = {{(REG_SIZE-16){~uns_q & halfVal[15]}}, halfVal};
            default: loadExt = mem_rdata_i;
        endcase
    end

    always_comb begin
        mergedWord = merge_q;
        case (size_q)
            2'b00:   mergedWord[{off_q, 3'b000} +: 8]     = wdata_q[7:0];
            2'b01:   mergedWord[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: mergedWord = wdata_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        memAddr_d = memAddr_q;
        off_d     = off_q;
        size_d    = size_q;
        we_d      = we_q;
        uns_d     = uns_q;
        wdata_d   = wdata_q;
        merge_d   = merge_q;
        done_o    = 1'b0;
        mem_we_o  = 1'b0;
        rdata_o   = '0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
                    off_d   = addr_i[1:0];
                    size_d  = size_i;
                    we_d    = we_i;
                    uns_d   = unsigned_i;
                    wdata_d = wdata_i;
`ifdef DMEM_MISALIGN_TRAP_EN
                    if (misaligned)
                        state_d = ERR;
                    else
`endif
                    if (we_i && size_i[1])
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD: begin
                memAddr_d = addr_q;
                if (we_q) begin
                    merge_d = mem_rdata_i;
                    state_d = WR;
                end else begin
                    done_o  = 1'b1;
                    rdata_o = loadExt;
                    state_d = IDLE;
                end
            end
            WR: begin
                memAddr_d = addr_q;
                mem_we_o  = 1'b1;
                done_o    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                // ERR: report completion without touching memory.
                done_o  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl with a small word memory standing in for data_mem.
// Build with +define+DMEM_MISALIGN_TRAP_EN to exercise the trap variant.
module tb_dmem_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    logic [31:0] mem [0:63];
    int          writeCount = 0;
    int          testsRun = 0;
    int          testsFailed = 0;

    dmem_ctrl #(.REG_SIZE(32), .ADDR_W(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i),
        .size_i(size_i), .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .ready_o(ready_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Word memory with combinational read and clocked write, like data_mem.
    assign mem_rdata_i = mem[mem_addr_o[7:2]];

    always @(posedge clk_i) begin
        if (mem_we_o) begin
            mem[mem_addr_o[7:2]] <= mem_wdata_o;
            writeCount <= writeCount + 1;
        end
    end

    // Present one request for a single cycle; returns at the negedge of the cycle after acceptance.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk_i);
        req_i = 1'b1; we_i = we; size_i = size; unsigned_i = uns; addr_i = addr; wdata_i = wdata;
        @(negedge clk_i);
        req_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        req_i = 1'b1; we_i = 1'b1; size_i = 2'b10; unsigned_i = 1'b0;
        addr_i = 32'h10; wdata_i = 32'h12345678;
        repeat (3) @(negedge clk_i);
        testsRun++; if (ready_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_ready: got %b expected 1", ready_o); end
        testsRun++; if (done_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %b expected 0", done_o); end
        testsRun++; if (mem_we_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_we: got %b expected 0", mem_we_o); end
        testsRun++; if (err_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_err: got %b expected 0", err_o); end
        testsRun++; if (rdata_o !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata_o); end
        testsRun++; if (mem_addr_o !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_addr: got %h expected 0", mem_addr_o); end
        testsRun++; if (mem_wdata_o !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_wdata: got %h expected 0", mem_wdata_o); end
        testsRun++; if (writeCount !== 0) begin testsFailed++; $display("[TB] FAIL reset_writes: got %0d expected 0", writeCount); end
        req_i = 1'b0;
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_word();
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        testsRun++; if (mem_we_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL sw_we: got %b expected 1", mem_we_o); end
        testsRun++; if (mem_wdata_o !== 32'hDEADBEEF) begin testsFailed++; $display("[TB] FAIL sw_wdata: got %h expected deadbeef", mem_wdata_o); end
        testsRun++; if (mem_addr_o !== 32'h10) begin testsFailed++; $display("[TB] FAIL sw_addr: got %h expected 00000010", mem_addr_o); end
        testsRun++; if (done_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL sw_done: got %b expected 1", done_o); end
        testsRun++; if (ready_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL sw_busy: got %b expected 0", ready_o); end
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        testsRun++; if (done_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL lw_done: got %b expected 1", done_o); end
        testsRun++; if (rdata_o !== 32'hDEADBEEF) begin testsFailed++; $display("[TB] FAIL lw_rdata: got %h expected deadbeef", rdata_o); end
        testsRun++; if (mem_we_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL lw_we: got %b expected 0", mem_we_o); end
        @(negedge clk_i);
        testsRun++; if (ready_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL lw_ready_after: got %b expected 1", ready_o); end
        testsRun++; if (done_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL lw_done_after: got %b expected 0", done_o); end
    endtask

    task automatic test_subword_store();
        // Upper wdata bits are junk on purpose; only the low lane(s) may land.
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF55);
        testsRun++; if (mem_we_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL sb_rd_we: got %b expected 0", mem_we_o); end
        testsRun++; if (done_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL sb_rd_done: got %b expected 0", done_o); end
        testsRun++; if (mem_addr_o !== 32'h10) begin testsFailed++; $display("[TB] FAIL sb_rd_addr: got %h expected 00000010", mem_addr_o); end
        @(negedge clk_i);
        testsRun++; if (mem_we_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL sb_wr_we: got %b expected 1", mem_we_o); end
        testsRun++; if (mem_wdata_o !== 32'hDEAD55EF) begin testsFailed++; $display("[TB] FAIL sb_wdata: got %h expected dead55ef", mem_wdata_o); end
        testsRun++; if (done_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL sb_wr_done: got %b expected 1", done_o); end
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD1234);
        @(negedge clk_i);
        testsRun++; if (mem_wdata_o !== 32'h123455EF) begin testsFailed++; $display("[TB] FAIL sh_wdata: got %h expected 123455ef", mem_wdata_o); end
        testsRun++; if (mem_we_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL sh_wr_we: got %b expected 1", mem_we_o); end
    endtask

    task automatic test_load_ext();
        logic [31:0] addrTab [0:6];
        logic [1:0]  sizeTab [0:6];
        logic        unsTab  [0:6];
        logic [31:0] expTab  [0:6];
        addrTab = '{32'h11, 32'h13, 32'h10, 32'h10, 32'h10, 32'h16, 32'h16};
        sizeTab = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01};
        unsTab  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        expTab  = '{32'h00000055, 32'h00000012, 32'h000055EF, 32'h000000EF,
                    32'hFFFFFFEF, 32'hFFFF80FF, 32'h000080FF};
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h14, 32'h80FF0000);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, sizeTab[i], unsTab[i], addrTab[i], 32'h0);
            testsRun++;
            if (done_o !== 1'b1 || rdata_o !== expTab[i]) begin
                testsFailed++;
                $display("[TB] FAIL load_ext[%0d] @%h: got done=%b rdata=%h expected done=1 rdata=%h",
                         i, addrTab[i], done_o, rdata_o, expTab[i]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int writesBefore;
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h20, 32'h11111111);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h20, 32'h00000099);
        writesBefore = writeCount;
        rst_ni = 1'b0;
        #2;
        testsRun++; if (ready_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL abort_ready: got %b expected 1", ready_o); end
        testsRun++; if (done_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_done: got %b expected 0", done_o); end
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        testsRun++; if (mem_we_o !== 1'b0 || done_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_no_write: got we=%b done=%b expected 0 0", mem_we_o, done_o); end
        testsRun++; if (writeCount !== writesBefore) begin testsFailed++; $display("[TB] FAIL abort_writes: got %0d expected %0d", writeCount, writesBefore); end
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        testsRun++; if (rdata_o !== 32'h11111111) begin testsFailed++; $display("[TB] FAIL abort_lw: got %h expected 11111111", rdata_o); end
    endtask

    task automatic test_misalign();
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h21, 32'hA5A5A5A5);
`ifdef DMEM_MISALIGN_TRAP_EN
        testsRun++; if (err_o !== 1'b1 || done_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL mis_err: got err=%b done=%b expected 1 1", err_o, done_o); end
        testsRun++; if (mem_we_o !== 1'b0 || rdata_o !== 32'h0) begin testsFailed++; $display("[TB] FAIL mis_quiet: got we=%b rdata=%h expected 0 0", mem_we_o, rdata_o); end
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        testsRun++; if (rdata_o !== 32'h11111111) begin testsFailed++; $display("[TB] FAIL mis_mem: got %h expected 11111111", rdata_o); end
        testsRun++; if (err_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL mis_err_clear: got %b expected 0", err_o); end
`else
        testsRun++; if (err_o !== 1'b0 || mem_we_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL mis_write: got err=%b we=%b expected 0 1", err_o, mem_we_o); end
        testsRun++; if (mem_addr_o !== 32'h20) begin testsFailed++; $display("[TB] FAIL mis_addr: got %h expected 00000020", mem_addr_o); end
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        testsRun++; if (rdata_o !== 32'hA5A5A5A5) begin testsFailed++; $display("[TB] FAIL mis_mem: got %h expected a5a5a5a5", rdata_o); end
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h23, 32'h0);
        testsRun++; if (rdata_o !== 32'hFFFFA5A5) begin testsFailed++; $display("[TB] FAIL mis_lh: got %h expected ffffa5a5", rdata_o); end
`endif
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword_store();
        test_load_ext();
        test_reset_abort();
        test_misalign();
        repeat (2) @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Guard against a stuck simulation; normal runs finish long before this.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Sequencer between the pipeline's load/store stage and the word-wide `data_mem`. Accepts RV32 loads and stores of byte, halfword and word size, and drives `data_mem`'s single port. Performs read-modify-write for sub-word stores because `data_mem` only writes whole words. Extracts and sign- or zero-extends load data, and holds the core off through `ready_o` while an access is in flight.

## Interface
- `REG_SIZE`, 32: data width; fixed at 32, four byte lanes.
- `ADDR_W`, 32: byte-address width.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `req_i` in 1: request valid from the core.
- `we_i` in 1: 1 = store, 0 = load.
- `size_i` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `unsigned_i` in 1: zero-extend on loads (LBU/LHU); ignored on stores.
- `addr_i` in ADDR_W: byte address.
- `wdata_i` in REG_SIZE: store data, LSB-aligned.
- `ready_o` out 1: controller idle; a request is accepted when `req_i & ready_o` at a rising edge.
- `done_o` out 1: one-cycle completion pulse.
- `rdata_o` out REG_SIZE: extended load data; valid only while `done_o` is high for a load.
- `err_o` out 1: misaligned access; see Configuration.
- `mem_we_o` out 1: `data_mem` write enable.
- `mem_addr_o` out ADDR_W: word-aligned address to `data_mem` (bits [1:0] are always 0).
- `mem_wdata_o` out REG_SIZE: write data to `data_mem`.
- `mem_rdata_i` in REG_SIZE: `data_mem` read data, combinational from `mem_addr_o`.

## Operation
- FSM states are IDLE, RD, WR and ERR.
- Acceptance
  - Happens in IDLE when `req_i` is high.
  - Captures into internal registers: the aligned address (`addr_i & ~3`), the offset `addr_i[1:0]`, `size_i`, `we_i`, `unsigned_i` and `wdata_i`.
- Transitions out of IDLE on acceptance:
  - load → RD;
  - word store → WR;
  - byte/half store → RD;
  - misaligned access with the trap compiled in → ERR.
- RD
  - Drives `mem_addr_o`, with `mem_we_o=0`.
  - Load: `done_o=1`, `rdata_o` = extracted lane(s) of `mem_rdata_i`, then → IDLE.
  - Sub-word store: latches `mem_rdata_i` into the merge buffer, then → WR.
- WR
  - `mem_we_o=1`, `done_o=1`, then → IDLE.
  - `mem_wdata_o` is `wdata` for a word store, or the merge buffer with the target lanes replaced for a sub-word store.
- ERR: `done_o=1`, `err_o=1`, `rdata_o=0`, no memory access, then → IDLE.
- Load extraction
  - Byte: lane = offset, using bits [8·off+7 : 8·off].
  - Half: bits [16·addr[1]+15 : 16·addr[1]].
  - Sign-extend from the MSB of the extracted field unless `unsigned_i` is set.
- Merge
  - Byte store replaces lane `off` with `wdata[7:0]`.
  - Half store replaces lanes `{addr[1],0}` and `{addr[1],1}` with `wdata[15:0]`.
  - All other lanes keep their read value.
- `ready_o` = (state == IDLE). `req_i` is ignored outside IDLE and needs no hold.
- Outside RD/WR, `mem_addr_o` holds its last value; `mem_we_o` is 0 outside WR.

## Timing
- Request accepted at the end of cycle c:
  - Load: `done_o` and `rdata_o` in cycle c+1.
  - Word store: write committed at the end of cycle c+1, `done_o` in c+1.
  - Sub-word store: read in c+1; write and `done_o` in c+2.
  - Error: `done_o` and `err_o` in c+1.
- `ready_o` rises in the cycle after `done_o`. Back-to-back throughput is one op per 2 cycles (per 3 cycles for sub-word stores).
- A load that immediately follows a store to the same word sees the stored value, because the write commits before RD.
- Reset values
  - State IDLE, so `ready_o=1`.
  - `done_o=0`, `err_o=0`, `mem_we_o=0`, `rdata_o=0`, `mem_addr_o=0`, `mem_wdata_o=0`; captured registers and merge buffer 0.
  - Requests are not accepted while `rst_ni` is low.
- Reset mid-operation aborts immediately.
  - Asserting reset during RD of a sub-word store leaves memory unchanged, since no partial write is ever issued.
  - No `done_o` is produced for the aborted request.

## Configuration
- Macro: `DMEM_MISALIGN_TRAP_EN`.
- Defined
  - A half access with `addr[0]=1`, or a word access with `addr[1:0]!=0`, goes to ERR.
  - For misaligned stores, memory is untouched.
- Undefined
  - No ERR state; `err_o` is tied to 0.
  - Word accesses ignore `addr[1:0]`; half accesses ignore `addr[0]`.
  - The access proceeds on the aligned-down address.

## Test plan
- Reset with `rst_ni=0` while `req_i=1` → `ready_o=1`, `done_o=0`, `mem_we_o=0`; no access issued.
- SW 0xDEADBEEF @0x10, then LW @0x10 → `mem_we_o` pulse with `mem_wdata_o=0xDEADBEEF`; load returns 0xDEADBEEF one cycle after acceptance.
- With word @0x10 = 0xDEADBEEF:
  - SB 0x55 @0x11 → `mem_wdata_o=0xDEAD55EF` two cycles after acceptance.
  - SH 0x1234 @0x12 → 0x123455EF.
- With word @0x10 = 0x123455EF:
  - LB @0x11 → 0x00000055.
  - LB @0x13 → 0x00000012.
  - LH @0x10 → 0x000055EF.
  - LBU @0x10 → 0x000000EF.
  - With word = 0x80FF0000: LH @0x12 → 0xFFFF80FF; LHU @0x12 → 0x000080FF.
- `rst_ni` pulsed low during RD of SB @0x20 (old word 0x11111111) → FSM returns to IDLE, no write issued, LW @0x20 returns 0x11111111.
- `DMEM_MISALIGN_TRAP_EN` defined: SW @0x21 → `err_o=1`, `done_o=1`, memory unchanged. Undefined: the same SW writes word 0x20, `err_o=0`.
